// File: rtl/mul4_fitness_sequencer_pkg.sv
// Shared types, constants and the golden mul4 model for the fitness sequencer.
package mul4_fit_pkg;

  localparam int LANE_W = 16;
  localparam int LFSR_W = 64;
  // Fibonacci taps 64,63,61,60 expressed as bit positions 63,62,60,59.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SAMPLE = 3'd2,
    FIN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  typedef logic [3:0][LANE_W-1:0] lane_t;

  // Lane 3 is the most significant 16 bits of the 64-bit product (y3).
  function automatic lane_t golden_mul4(input logic [LANE_W-1:0] a1, a0, b1, b0);
    logic [63:0] p;
    p = {32'h0, a1, a0} * {32'h0, b1, b0};
    return p;
  endfunction

  function automatic logic [2:0] lane_hits(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/mul4_fitness_sequencer_if.sv
// Control and candidate-operand bus between the sequencer and its environment.
interface mul4_fit_if
  import mul4_fit_pkg::*;
#(
  parameter int NUM_VECTORS = 256
);
  localparam int SW = $clog2(4*NUM_VECTORS+1);

  logic              start;
  logic              busy;
  logic              done;
  logic [SW-1:0]     score;
  logic [LANE_W-1:0] dut_a1, dut_a0, dut_b1, dut_b0;
  logic [LANE_W-1:0] dut_y3, dut_y2, dut_y1, dut_y0;

  modport master (
    input  start, dut_y3, dut_y2, dut_y1, dut_y0,
    output busy, done, score, dut_a1, dut_a0, dut_b1, dut_b0
  );

  modport slave (
    output start, dut_y3, dut_y2, dut_y1, dut_y0,
    input  busy, done, score, dut_a1, dut_a0, dut_b1, dut_b0
  );
endinterface

// File: rtl/mul4_fitness_sequencer_lfsr.sv
// 64-bit Fibonacci LFSR (shift left, feedback into bit 0) with seed load and step enable.
module mul4_fit_lfsr
  import mul4_fit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 64'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] q,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};

  always_ff @(posedge clk) begin
    if (rst)       q <= SEED;
    else if (load) q <= seed;
    else if (step) q <= nxt;
  end

endmodule

// File: rtl/mul4_fitness_sequencer.sv
// Tournament fitness sequencer: drives LFSR operand vectors into a candidate mul4 and scores it.
// Build option MUL4_FIT_LANE_SCORE_EN: score per matching lane instead of per fully matching vector.
module mul4_fitness_sequencer
  import mul4_fit_pkg::*;
#(
  parameter int                NUM_VECTORS   = 256,
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [LFSR_W-1:0] SEED          = 64'hACE1_0000_0001
) (
  input  logic       clk,
  input  logic       rst,
  mul4_fit_if.master bus
);

  localparam int SW = $clog2(4*NUM_VECTORS+1);
  localparam int VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES+1) : 1;
  localparam logic [SW-1:0]     SCORE_MAX = SW'(4*NUM_VECTORS);
  localparam logic [LFSR_W-1:0] SEED_EFF  = (SEED == '0) ? 64'h1 : SEED;

  state_t            state;
  logic [VW-1:0]     vec_cnt;
  logic [CW-1:0]     settle_cnt;
  logic [SW-1:0]     score_q;
  logic [LFSR_W-1:0] opnd;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  lane_t             golden_p1;
  lane_t             y;
  logic [3:0]        match;
  logic [2:0]        add;
  logic              accept;

  function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] s, input logic [2:0] a);
    logic [SW:0] sum;
    sum = {1'b0, s} + (SW+1)'(a);
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SW-1:0];
  endfunction

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  mul4_fit_lfsr #(.SEED(SEED_EFF)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .seed (SEED_EFF),
    .step (state == SAMPLE),
    .q    (lfsr_q),
    .nxt  (lfsr_nxt)
  );

  // Operands are captured on DRIVE entry and only move when the LFSR advances.
  always_ff @(posedge clk) begin
    if (rst)                  opnd <= '0;
    else if (accept)          opnd <= SEED_EFF;
    else if (state == SAMPLE) opnd <= lfsr_nxt;
  end

  // Stage p1: golden product of the held operands, computed from the LFSR, never from the candidate.
  always_ff @(posedge clk) begin
    if (state == DRIVE)
      golden_p1 <= golden_mul4(lfsr_q[63:48], lfsr_q[47:32], lfsr_q[31:16], lfsr_q[15:0]);
  end

  assign y = {bus.dut_y3, bus.dut_y2, bus.dut_y1, bus.dut_y0};

  always_comb begin
    for (int i = 0; i < 4; i++) match[i] = (y[i] == golden_p1[i]);
`ifdef MUL4_FIT_LANE_SCORE_EN
    add = lane_hits(match);
`else
    add = {2'b00, &match};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      score_q    <= '0;
      vec_cnt    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= DRIVE;
            score_q    <= '0;
            vec_cnt    <= '0;
            settle_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (settle_cnt == CW'(SETTLE_CYCLES)) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          score_q <= sat_add(score_q, add);
          vec_cnt <= vec_cnt + 1'b1;
          state   <= (vec_cnt == VW'(NUM_VECTORS-1)) ? FIN : DRIVE;
        end
        FIN:     state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == DRIVE) || (state == SAMPLE);
  assign bus.done   = (state == FIN);
  assign bus.score  = score_q;
  assign bus.dut_a1 = opnd[63:48];
  assign bus.dut_a0 = opnd[47:32];
  assign bus.dut_b1 = opnd[31:16];
  assign bus.dut_b0 = opnd[15:0];

endmodule
